// File: rtl/fifo_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_defs : shared defaults, operation encoding and clog2 helper     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fifo_defs;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2, usable in constant context; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_sync_ram : DEPTH x WIDTH register array, 1 write / 1 async read |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module fifo_sync_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_sync_param : parametrised synchronous FIFO, ready/enable sides, |
// |                   occupancy count, almost flags and sync flush       |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module fifo_sync_param
  import fifo_defs::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  localparam int CW      = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             enable_out,
  input  logic             ready_in,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW = clog2(DEPTH);

  localparam logic [CW-1:0] c_depth  = CW'(DEPTH);
  localparam logic [CW-1:0] c_one    = CW'(1);
  localparam logic [CW-1:0] c_af_lvl = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae_lvl = CW'(AE_LEVEL);
  localparam logic [PW-1:0] c_last   = PW'(DEPTH - 1);

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_af, r_ae;
  logic             r_out_zero;

  logic             w_push, w_pop, w_we;
  fifo_op_e         w_op;
  logic [PW-1:0]    w_wr_nxt, w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_rd_data;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] f_adv(input logic [PW-1:0] p);
    return (p == c_last) ? '0 : p + PW'(1);
  endfunction

  assign ready_out  = (r_count != c_depth);
  assign enable_out = (r_count != '0);
  assign w_push     = enable_in & ready_out;
  assign w_pop      = enable_out & ready_in;
  assign w_op       = fifo_op_e'({w_pop, w_push});
  assign w_we       = w_push & ~flush;

  always_comb begin
    w_wr_nxt  = r_wr_ptr;
    w_rd_nxt  = r_rd_ptr;
    w_cnt_nxt = r_count;
    if (flush) begin
      w_wr_nxt  = '0;
      w_rd_nxt  = '0;
      w_cnt_nxt = '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          w_wr_nxt  = f_adv(r_wr_ptr);
          w_cnt_nxt = r_count + c_one;
        end
        OP_POP: begin
          w_rd_nxt  = f_adv(r_rd_ptr);
          w_cnt_nxt = r_count - c_one;
        end
        OP_BOTH: begin
          w_wr_nxt = f_adv(r_wr_ptr);
          w_rd_nxt = f_adv(r_rd_ptr);
        end
        default: ;
      endcase
    end
  end

  // r_out_zero keeps data_out at 0 after reset until storage is first written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_out_zero <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_af     <= (w_cnt_nxt >= c_af_lvl);
      r_ae     <= (w_cnt_nxt <= c_ae_lvl);
      if (w_we) r_out_zero <= 1'b0;
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign data_out     = r_out_zero ? '0 : w_rd_data;
  assign count        = r_count;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_sync_param : vector table, directed corners and a randomised |
// |                      run against a queue reference (DEPTH 4 and 5)   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module tb_fifo_sync_param;

  typedef struct {
    logic       fl;
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] cnt;
    logic       ro;
    logic       eo;
    logic       cd;
    logic [7:0] dout;
    logic       af;
    logic       ae;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fl4, en4, rdy4, fl5, en5, rdy5;
  logic [7:0] d4, d5;
  logic       ro4, eo4, af4, ae4, ro5, eo5, af5, ae5;
  logic [7:0] q4_out, q5_out;
  logic [2:0] cnt4, cnt5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut4 (
    .clk(clk), .reset_n(reset_n), .flush(fl4), .data_in(d4), .enable_in(en4),
    .ready_out(ro4), .data_out(q4_out), .enable_out(eo4), .ready_in(rdy4),
    .count(cnt4), .almost_full(af4), .almost_empty(ae4)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .clk(clk), .reset_n(reset_n), .flush(fl5), .data_in(d5), .enable_in(en5),
    .ready_out(ro5), .data_out(q5_out), .enable_out(eo5), .ready_in(rdy5),
    .count(cnt5), .almost_full(af5), .almost_empty(ae5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input int cnt, input int ro, input int eo,
                      input int cd, input int dout, input int af, input int ae);
    chk({tag, " count"},   32'(cnt4), 32'(cnt));
    chk({tag, " ready"},   32'(ro4),  32'(ro));
    chk({tag, " enable"},  32'(eo4),  32'(eo));
    chk({tag, " afull"},   32'(af4),  32'(af));
    chk({tag, " aempty"},  32'(ae4),  32'(ae));
    if (cd != 0) chk({tag, " data"}, 32'(q4_out), 32'(dout));
  endtask

  task automatic drive4(input logic fl, input logic en, input logic [7:0] d, input logic rdy);
    fl4 = fl; en4 = en; d4 = d; rdy4 = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int fl, input int en, input int d, input int rdy,
                              input int cnt, input int ro, input int eo, input int cd,
                              input int dout, input int af, input int ae);
    vec_t v;
    v.fl = fl[0]; v.en = en[0]; v.d = d[7:0]; v.rdy = rdy[0];
    v.cnt = cnt[2:0]; v.ro = ro[0]; v.eo = eo[0]; v.cd = cd[0];
    v.dout = dout[7:0]; v.af = af[0]; v.ae = ae[0];
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[$];
    logic [7:0] q4[$];
    logic [7:0] q5[$];
    logic [7:0] d;
    logic       exp_ro, exp_eo;

    //          fl en d     rdy cnt ro eo cd dout  af ae
    vt.push_back(mk(0, 1, 'h55, 0, 1, 1, 1, 1, 'h55, 0, 1));
    vt.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 0, 'h00, 0, 1));
    vt.push_back(mk(0, 1, 'hA1, 0, 1, 1, 1, 1, 'hA1, 0, 1));
    vt.push_back(mk(0, 1, 'hA2, 0, 2, 1, 1, 1, 'hA1, 0, 0));
    vt.push_back(mk(0, 1, 'hA3, 0, 3, 1, 1, 1, 'hA1, 1, 0));
    vt.push_back(mk(0, 1, 'hA4, 0, 4, 0, 1, 1, 'hA1, 1, 0));
    vt.push_back(mk(0, 1, 'hEE, 1, 3, 1, 1, 1, 'hA2, 1, 0));
    vt.push_back(mk(0, 1, 'hA5, 0, 4, 0, 1, 1, 'hA2, 1, 0));
    vt.push_back(mk(0, 0, 'h00, 1, 3, 1, 1, 1, 'hA3, 1, 0));
    vt.push_back(mk(0, 0, 'h00, 1, 2, 1, 1, 1, 'hA4, 0, 0));
    vt.push_back(mk(0, 0, 'h00, 1, 1, 1, 1, 1, 'hA5, 0, 1));
    vt.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 0, 'h00, 0, 1));
    vt.push_back(mk(0, 1, 'hB1, 0, 1, 1, 1, 1, 'hB1, 0, 1));
    vt.push_back(mk(0, 1, 'hB2, 0, 2, 1, 1, 1, 'hB1, 0, 0));
    vt.push_back(mk(0, 1, 'hB3, 0, 3, 1, 1, 1, 'hB1, 1, 0));
    vt.push_back(mk(1, 1, 'hCC, 0, 0, 1, 0, 0, 'h00, 0, 1));
    vt.push_back(mk(0, 1, 'hD1, 0, 1, 1, 1, 1, 'hD1, 0, 1));
    vt.push_back(mk(0, 1, 'hD2, 1, 1, 1, 1, 1, 'hD2, 0, 1));
    vt.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 0, 'h00, 0, 1));
    vt.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 0, 'h00, 0, 1));

    reset_n = 1'b0;
    fl4 = 0; en4 = 0; d4 = 0; rdy4 = 0;
    fl5 = 0; en5 = 0; d5 = 0; rdy5 = 0;
    #12;
    chk4("reset4", 0, 1, 0, 1, 0, 0, 1);
    chk("reset5 count", 32'(cnt5), 0);
    chk("reset5 data",  32'(q5_out), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      drive4(vt[i].fl, vt[i].en, vt[i].d, vt[i].rdy);
      chk4($sformatf("vec%0d", i), int'(vt[i].cnt), int'(vt[i].ro), int'(vt[i].eo),
           int'(vt[i].cd), int'(vt[i].dout), int'(vt[i].af), int'(vt[i].ae));
    end

    // Continuous push/pop at count 2 across several pointer wraps.
    drive4(0, 1, 8'hE0, 0); q4.push_back(8'hE0);
    drive4(0, 1, 8'hE1, 0); q4.push_back(8'hE1);
    for (int i = 0; i < 10; i++) begin
      d = 8'hE2 + 8'(i);
      drive4(0, 1, d, 1);
      void'(q4.pop_front());
      q4.push_back(d);
      chk4($sformatf("pp%0d", i), 2, 1, 1, 1, int'(q4[0]), 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      drive4(0, 0, 8'h00, 1);
      void'(q4.pop_front());
      chk4($sformatf("ppdrain%0d", i), q4.size(), 1, int'(q4.size() != 0),
           int'(q4.size() != 0), (q4.size() != 0) ? int'(q4[0]) : 0, 0, 1);
    end

    // Asynchronous reset in the middle of a cycle with words stored.
    drive4(0, 1, 8'h71, 0);
    drive4(0, 1, 8'h72, 0);
    drive4(0, 1, 8'h73, 1);
    en4 = 0; rdy4 = 0;
    #2 reset_n = 1'b0;
    #1;
    chk4("midreset", 0, 1, 0, 1, 0, 0, 1);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk4("postreset", 0, 1, 0, 1, 0, 0, 1);

    // Random traffic into the 5-deep instance against a queue model.
    for (int i = 0; i < 400; i++) begin
      fl5  = ($urandom_range(0, 31) == 0);
      en5  = ($urandom_range(0, 9) < 7);
      d5   = 8'($urandom);
      rdy5 = ($urandom_range(0, 9) < ((i < 200) ? 4 : 8));
      exp_ro = (q5.size() != 5);
      exp_eo = (q5.size() != 0);
      @(posedge clk);
      if (fl5) begin
        q5.delete();
      end else begin
        if (exp_eo && rdy5) void'(q5.pop_front());
        if (en5 && exp_ro) q5.push_back(d5);
      end
      #1;
      chk($sformatf("rnd%0d count", i),  32'(cnt5), 32'(q5.size()));
      chk($sformatf("rnd%0d ready", i),  32'(ro5),  32'(q5.size() != 5));
      chk($sformatf("rnd%0d enable", i), 32'(eo5),  32'(q5.size() != 0));
      chk($sformatf("rnd%0d afull", i),  32'(af5),  32'(q5.size() >= 4));
      chk($sformatf("rnd%0d aempty", i), 32'(ae5),  32'(q5.size() <= 1));
      if (q5.size() != 0) chk($sformatf("rnd%0d data", i), 32'(q5_out), 32'(q5[0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
